// File: rtl/hdmi_int_filter_pkg.sv
// rtl/hdmi_int_filter_pkg.sv - register map and bit index constants for hdmi_int_filter
package hdmi_int_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EVTCNT = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  localparam int STAT_LEVEL_BIT = 0;
  localparam int STAT_SYNC_BIT  = 1;
  localparam int MASK_BIT       = 0;
  localparam int EDGE_BIT       = 0;

endpackage

// File: rtl/hdmi_int_filter_if.sv
// rtl/hdmi_int_filter_if.sv - Avalon-MM register port bundle for hdmi_int_filter
interface hdmi_int_filter_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/hdmi_int_filter_debounce.sv
// rtl/hdmi_int_filter_debounce.sv - int_debounce: pin synchroniser plus stable-count filter
module int_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic int_n_pin,
  output logic sync_n,
  output logic filt_n
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          dcnt;

  assign sync_n = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser; idle (high) out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_n_pin};
    end
  end

  // Accept the synchronised level only after it has differed for FILTER_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_n <= 1'b1;
      dcnt   <= '0;
    end else if (sync_n == filt_n) begin
      dcnt <= '0;
    end else if (dcnt == LAST) begin
      filt_n <= sync_n;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_int_filter.sv
// rtl/hdmi_int_filter.sv - HDMI TX interrupt conditioner top; event counter under HDMI_INT_EVENT_CNT_EN
module hdmi_int_filter
  import hdmi_int_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int EVT_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                int_n_pin,
  hdmi_int_filter_if.slave    bus,
  output logic                int_level,
  output logic                irq
);

  logic             sync_n;
  logic             filt_n;
  logic             filt_d;
  logic             edge_set;
  logic             edge_cap;
  logic             mask;
  logic             wr_en;
  logic [EVT_W-1:0] evt_cnt;
  logic [30:0]      unused_wdata;

  assign unused_wdata = bus.writedata[31:1];

  int_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .int_n_pin (int_n_pin),
    .sync_n    (sync_n),
    .filt_n    (filt_n)
  );

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign edge_set = filt_d && !filt_n;
  assign irq      = edge_cap && mask;

  // Delay filt_n for edge detection and register the clean active-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d    <= 1'b1;
      int_level <= 1'b0;
    end else begin
      filt_d    <= filt_n;
      int_level <= ~filt_n;
    end
  end

  // Edge capture: a new assertion wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= 1'b0;
    end else if (edge_set) begin
      edge_cap <= 1'b1;
    end else if (wr_en && bus.address == ADDR_EDGE && bus.writedata[EDGE_BIT]) begin
      edge_cap <= 1'b0;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= 1'b0;
    end else if (wr_en && bus.address == ADDR_MASK) begin
      mask <= bus.writedata[MASK_BIT];
    end
  end

`ifdef HDMI_INT_EVENT_CNT_EN
  logic evt_clr;
  assign evt_clr = wr_en && (bus.address == ADDR_EVTCNT);

  // Saturating event counter; a clear coinciding with an event leaves a count of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= edge_set ? EVT_W'(1) : '0;
    end else if (edge_set && !(&evt_cnt)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end
`else
  assign evt_cnt = '0;
`endif

  // Registered read mux, refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= '0;
      case (bus.address)
        ADDR_STATUS: begin
          bus.readdata[STAT_LEVEL_BIT] <= int_level;
          bus.readdata[STAT_SYNC_BIT]  <= ~sync_n;
        end
        ADDR_EVTCNT: bus.readdata[EVT_W-1:0] <= evt_cnt;
        ADDR_MASK:   bus.readdata[MASK_BIT]  <= mask;
        default:     bus.readdata[EDGE_BIT]  <= edge_cap;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_int_filter.sv
// tb/tb_hdmi_int_filter.sv - directed bench for hdmi_int_filter; counter checks follow HDMI_INT_EVENT_CNT_EN
module tb_hdmi_int_filter;

  logic clk = 1'b0;
  logic reset;
  logic int_n_pin;
  logic int_level;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] rdat;
  logic bad;

  hdmi_int_filter_if bus ();

  hdmi_int_filter #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (16),
    .EVT_W         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .int_n_pin (int_n_pin),
    .bus       (bus),
    .int_level (int_level),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic assert_pin();
    int_n_pin = 1'b0;
    repeat (22) tick();
    int_n_pin = 1'b1;
    repeat (22) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    int_n_pin      = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset with the pin held low
    repeat (5) tick();
    chk("rst_level", {31'b0, int_level}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    reset = 1'b0;
    repeat (18) tick();
    chk("rel_level_18", {31'b0, int_level}, 32'd0);
    tick();
    chk("rel_level_19", {31'b0, int_level}, 32'd1);
    int_n_pin = 1'b1;
    repeat (25) tick();
    rd(2'd3, rdat);
    chk("rel_edge", rdat, 32'd1);
    wr(2'd3, 32'd1);
    rd(2'd3, rdat);
    chk("edge_clr", rdat, 32'd0);

    // Glitch of 15 cycles is rejected
    bad = 1'b0;
    int_n_pin = 1'b0;
    repeat (15) begin
      tick();
      bad |= int_level | irq;
    end
    int_n_pin = 1'b1;
    repeat (30) begin
      tick();
      bad |= int_level | irq;
    end
    chk("glitch_out", {31'b0, bad}, 32'd0);
    rd(2'd0, rdat);
    chk("glitch_stat", rdat, 32'd0);
    rd(2'd3, rdat);
    chk("glitch_edge", rdat, 32'd0);

    // Masked assertion
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, rdat);
    chk("mask_rd", rdat, 32'd1);
    int_n_pin = 1'b0;
    repeat (18) tick();
    chk("asrt_irq_18", {30'b0, int_level, irq}, 32'd0);
    tick();
    chk("asrt_irq_19", {30'b0, int_level, irq}, 32'd3);
    rd(2'd0, rdat);
    chk("asrt_stat", rdat, 32'd3);
    rd(2'd3, rdat);
    chk("asrt_edge", rdat, 32'd1);
    wr(2'd3, 32'd1);
    chk("clr_irq", {30'b0, int_level, irq}, 32'd2);
    int_n_pin = 1'b1;
    repeat (25) tick();
    chk("deasrt_level", {31'b0, int_level}, 32'd0);

    // Clear write on the set cycle: set wins
    int_n_pin = 1'b0;
    repeat (18) tick();
    wr(2'd3, 32'd1);
    chk("coll_irq", {31'b0, irq}, 32'd1);
    rd(2'd3, rdat);
    chk("coll_edge", rdat, 32'd1);
    int_n_pin = 1'b1;
    repeat (25) tick();
    wr(2'd3, 32'd1);
    chk("coll_clr_irq", {31'b0, irq}, 32'd0);

`ifdef HDMI_INT_EVENT_CNT_EN
    // Saturation at 15 and clear colliding with an event
    wr(2'd1, 32'd0);
    rd(2'd1, rdat);
    chk("cnt_clr", rdat, 32'd0);
    for (int i = 0; i < 3; i++) assert_pin();
    rd(2'd1, rdat);
    chk("cnt_3", rdat, 32'd3);
    for (int i = 0; i < 17; i++) assert_pin();
    rd(2'd1, rdat);
    chk("cnt_sat", rdat, 32'd15);
    int_n_pin = 1'b0;
    repeat (18) tick();
    wr(2'd1, 32'd0);
    rd(2'd1, rdat);
    chk("cnt_coll", rdat, 32'd1);
    int_n_pin = 1'b1;
    repeat (25) tick();
`else
    // Counter absent: reads 0 and writes are ignored
    for (int i = 0; i < 3; i++) assert_pin();
    rd(2'd1, rdat);
    chk("nocnt_rd", rdat, 32'd0);
    wr(2'd1, 32'h5);
    rd(2'd1, rdat);
    chk("nocnt_wr", rdat, 32'd0);
`endif

    // Mid-filter reset returns everything to idle with no edge
    int_n_pin = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("midrst_out", {30'b0, int_level, irq}, 32'd0);
    chk("midrst_rdata", bus.readdata, 32'd0);
    int_n_pin = 1'b1;
    reset = 1'b0;
    repeat (30) tick();
    rd(2'd3, rdat);
    chk("midrst_edge", rdat, 32'd0);
    rd(2'd2, rdat);
    chk("midrst_mask", rdat, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_int_filter.md
# hdmi_int_filter

Input conditioner for the HDMI transmitter's open-drain, active-low interrupt pin. It synchronises and debounces the raw pin, latches assertion edges, and optionally counts interrupt events. It sits directly upstream of the HDMI TX interrupt PIO. Its clean, active-high level output drives the PIO's `in_port`, and its own Avalon-MM slave exposes edge-capture, mask and event-count registers for the Nios driver.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the input synchroniser; legal values ≥ 2.
- `FILTER_CYCLES`, default 16: consecutive stable cycles required before the filtered level changes; legal values ≥ 1.
- `EVT_W`, default 16: width of the event counter.

Ports:
- `clk`  in  1: the only clock. All state is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `int_n_pin`  in  1: raw asynchronous interrupt pin, active low.
- `address`  in  2: Avalon-MM word address.
- `chipselect`  in  1: Avalon-MM select.
- `write_n`  in  1: Avalon-MM write strobe, active low.
- `writedata`  in  32: Avalon-MM write data.
- `readdata`  out  32: Avalon-MM read data, registered.
- `int_level`  out  1: filtered interrupt level, active high. Feeds the PIO `in_port`.
- `irq`  out  1: `edge_cap & mask`, active high.

## Operation
- Synchroniser: a chain of `SYNC_STAGES` flops. On reset every flop is 1 (pin idle). `sync_n` is the last stage.
- Debounce, with filtered state `filt_n` (reset 1) and a counter `dcnt` (reset 0):
  - If `sync_n == filt_n`, `dcnt` returns to 0.
  - Otherwise `dcnt` increments each cycle.
  - When `dcnt == FILTER_CYCLES-1` and the inputs still differ, `filt_n` takes `sync_n` and `dcnt` returns to 0.
- `int_level = ~filt_n`, registered, reset 0.
- Edge capture: `edge_cap` (reset 0) sets on the cycle after `filt_n` goes 1→0. A write to address 3 with `writedata[0] = 1` clears it. If set and clear occur in the same cycle, set wins.
- Mask: `mask` (reset 0) is written from `writedata[0]` at address 2.
- Event counter `evt_cnt` (reset 0, `EVT_W` bits):
  - Increments on each `edge_cap` set condition and saturates at all-ones.
  - Any write to address 1 clears it.
  - If a clear and an increment occur in the same cycle, the result is 1.
- Register map (unused bits read 0):
  - Address 0 is status: bit0 `int_level`, bit1 `~sync_n`. Read-only.
  - Address 1 is `evt_cnt`. Write clears it.
  - Address 2 is `mask` bit0. Read/write.
  - Address 3 is `edge_cap` bit0. Write 1 to clear.
- `irq` is combinational from `edge_cap & mask`.

## Timing
- `readdata` is registered. It updates every cycle from `address`, independent of `chipselect`, giving one cycle of read latency. Reset value is 0.
- Writes take effect on the clock edge where `chipselect && !write_n`.
- Pin change to `filt_n` change: `SYNC_STAGES + FILTER_CYCLES` cycles for a clean edge.
  - `int_level` and `edge_cap` follow `filt_n` one cycle later.
  - `irq` rises in the same cycle as `edge_cap`.
- A pulse on `sync_n` shorter than `FILTER_CYCLES` cycles produces no change on any output.
- Reset asserted mid-filter returns every register to its reset value in one cycle. No edge is generated by leaving reset.
- Reset values of all outputs: `readdata` 0, `int_level` 0, `irq` 0.

## Configuration
- `HDMI_INT_EVENT_CNT_EN` defined: the event counter is built as described above.
- Not defined:
  - No counter logic is built.
  - Address 1 reads 0 and writes to it are ignored.
  - All other behaviour is unchanged.

## Structure
- Package `hdmi_int_pkg` holds:
  - the address constants `ADDR_STATUS`, `ADDR_EVTCNT`, `ADDR_MASK` and `ADDR_EDGE` (0–3);
  - the bit index constants.
- Sub-module `int_debounce` contains the synchroniser, the debounce counter and `filt_n`. It is parameterised by `SYNC_STAGES` and `FILTER_CYCLES`.
- The top level contains the edge detector, the registers, the counter and the read mux.

## Test plan
- Reset behaviour: assert `reset` with `int_n_pin = 0`, then release. All outputs stay 0 during reset. `int_level` reaches 1 exactly `SYNC_STAGES + FILTER_CYCLES + 1` cycles after release, and `edge_cap` sets on that same cycle.
- Glitch rejection: with defaults, drive `int_n_pin` low for 15 cycles, then high. `int_level`, `edge_cap` and `irq` stay 0. Reading address 0 returns 0 afterwards.
- Assertion with mask: set mask = 1, then hold the pin low. `int_level` goes 1 and `irq` goes 1 on cycle 19 after the pin change. Reading address 3 returns 1. Writing 1 to address 3 drops `irq` on the next cycle while `int_level` stays 1.
- Set/clear collision: schedule an address-3 clear write on the exact cycle of the `edge_cap` set condition. `edge_cap` stays 1.
- Counter saturation and clear (macro defined, `EVT_W = 4`):
  - 20 clean assertions read back 15.
  - A clear write coinciding with an assertion reads back 1.
- Counter compiled out (macro undefined): after 3 assertions, address 1 reads 0.
